// File: rtl/alu_pipe.sv
// Purpose: handshaked ALU with registered result, branch decision and N/Z/C/V flags, iterative MUL.
// Latency: 1 cycle accept-to-out_valid for non-MUL ops, WIDTH+1 cycles for MUL.
// Backpressure: in_ready drops while a multiply runs or a result is held with out_ready low.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic [3:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             branch,
  output logic [3:0]       flags
);

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_EOR  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_LSL  = 4'h6;
  localparam logic [3:0] OP_LSR  = 4'h7;
  localparam logic [3:0] OP_B    = 4'h8;
  localparam logic [3:0] OP_BL   = 4'h9;
  localparam logic [3:0] OP_CBZ  = 4'hA;
  localparam logic [3:0] OP_CBNZ = 4'hB;
  localparam logic [3:0] OP_ASR  = 4'hC;
  localparam logic [3:0] OP_PASS = 4'hF;

  localparam int              MSB      = WIDTH - 1;
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [3:0]       flg_q, flg_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic             big_sh;
  logic [WIDTH-1:0] op_res;
  logic             op_br;
  logic             op_c;
  logic             op_v;

  // Single-cycle evaluation of every opcode except MUL, plus branch decision.
  always_comb begin
    add_w  = {1'b0, busA} + {1'b0, busB};
    sub_w  = {1'b0, busA} - {1'b0, busB};
    // Shift distances are the full busB value, so anything >= WIDTH saturates.
    big_sh = (busB >= WIDTH_V);
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    case (ALUop)
      OP_AND: op_res = busA & busB;
      OP_OR:  op_res = busA | busB;
      OP_EOR: op_res = busA ^ busB;
      OP_ADD: begin
        op_res = add_w[WIDTH-1:0];
        op_c   = add_w[WIDTH];
        op_v   = (busA[MSB] == busB[MSB]) && (add_w[MSB] != busA[MSB]);
      end
      OP_SUB: begin
        op_res = sub_w[WIDTH-1:0];
        // Top bit of the widened difference is the borrow; C means no borrow.
        op_c   = ~sub_w[WIDTH];
        op_v   = (busA[MSB] != busB[MSB]) && (sub_w[MSB] != busA[MSB]);
      end
      OP_LSL:  op_res = big_sh ? '0 : (busA << busB);
      OP_LSR:  op_res = big_sh ? '0 : (busA >> busB);
      OP_ASR:  op_res = big_sh ? {WIDTH{busA[MSB]}} : WIDTH'($signed(busA) >>> busB);
      OP_PASS: op_res = busB;
      default: op_res = '0;
    endcase

    case (ALUop)
      OP_B, OP_BL: op_br = 1'b1;
      OP_CBZ:      op_br = (busB == '0);
      OP_CBNZ:     op_br = (busB != '0);
      default:     op_br = 1'b0;
    endcase
  end

  // Control FSM: handshake outputs, multiply iteration and result loading.
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    br_d      = br_q;
    flg_d     = flg_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_MULT: begin
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          res_d   = acc_d;
          br_d    = 1'b0;
          flg_d   = {acc_d[MSB], (acc_d == '0), 2'b00};
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        // Freeing the output slot in the same cycle lets a new op in without a bubble.
        in_ready  = out_ready;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (in_valid && in_ready) begin
      if (ALUop == OP_MUL) begin
        mcand_d  = busA;
        mplier_d = busB;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = S_MULT;
      end else begin
        res_d   = op_res;
        br_d    = op_br;
        flg_d   = {op_res[MSB], (op_res == '0), op_c, op_v};
        state_d = S_HOLD;
      end
    end
  end

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      br_q     <= 1'b0;
      flg_q    <= 4'b0000;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      br_q     <= br_d;
      flg_q    <= flg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result = res_q;
  assign branch = br_q;
  assign flags  = flg_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Purpose: scoreboard bench for alu_pipe with a behavioural reference model.
// Latency: expects out_valid 1 cycle after accept (17 for MUL).
// Backpressure: out_ready is driven high, low or randomly to exercise holding.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] busA;
  logic [15:0] busB;
  logic [3:0]  ALUop;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        branch;
  logic [3:0]  flags;

  alu_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .busA      (busA),
    .busB      (busB),
    .ALUop     (ALUop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .branch    (branch),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        br;
    logic [3:0]  flg;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   seen    = 1'b0;
  int   rdy_mode = 0;
  int   w;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: plain integer arithmetic on the opcode rules.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint ai = longint'(a);
    longint bi = longint'(b);
    longint sa = (ai >= 32768) ? ai - 65536 : ai;
    longint sb = (bi >= 32768) ? bi - 65536 : bi;
    longint r  = 0;
    longint s;
    bit     c  = 0;
    bit     v  = 0;
    bit     br = 0;
    case (op)
      4'h0: r = ai & bi;
      4'h1: r = ai | bi;
      4'h2: r = ai ^ bi;
      4'h3: r = (ai * bi) % 65536;
      4'h4: begin
        r = ai + bi; c = (r > 65535); s = sa + sb;
        v = (s > 32767) || (s < -32768); r = r % 65536;
      end
      4'h5: begin
        c = (ai >= bi); s = sa - sb;
        v = (s > 32767) || (s < -32768); r = (ai - bi + 65536) % 65536;
      end
      4'h6: r = (bi >= 16) ? 0 : (ai << bi) % 65536;
      4'h7: r = (bi >= 16) ? 0 : (ai >> bi);
      4'h8, 4'h9: br = 1;
      4'hA: br = (bi == 0);
      4'hB: br = (bi != 0);
      4'hC: r = (sa >>> ((bi > 15) ? 15 : bi)) & 65535;
      4'hF: r = bi;
      default: r = 0;
    endcase
    e.res = 16'(r);
    e.br  = br;
    e.flg = {(r >= 32768), (r == 0), c, v};
    e.cyc = 0;
    return e;
  endfunction

  // Present one op, hold it until accepted, record the expectation.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, output int waited);
    exp_t e;
    bit   done = 0;
    in_valid = 1'b1;
    ALUop    = op;
    busA     = a;
    busB     = b;
    waited   = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e     = model(op, a, b);
        e.cyc = cyc + ((op == 4'h3) ? 17 : 1);
        exp_q.push_back(e);
        done  = 1;
      end else begin
        waited++;
        if (waited > 100) begin
          chk("accept_timeout", 32'(waited), 32'd100);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    busA     = 16'($urandom);
    busB     = 16'($urandom);
    ALUop    = 4'($urandom);
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare every presented output against the scoreboard head.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      chk("in_ready_while_valid", 32'(in_ready), 32'(out_ready));
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        if (!seen) begin
          chk("latency", 32'(cyc), 32'(exp_q[0].cyc));
          seen = 1'b1;
        end
        chk("result", 32'(result), 32'(exp_q[0].res));
        chk("branch", 32'(branch), 32'(exp_q[0].br));
        chk("flags", 32'(flags), 32'(exp_q[0].flg));
        if (out_ready) begin
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          k;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    busA     = '0;
    busB     = '0;
    ALUop    = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_branch", 32'(branch), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed arithmetic and branch cases
    issue(4'h4, 16'h7FFF, 16'h0001, w);
    issue(4'h5, 16'd5, 16'd5, w);
    issue(4'hA, 16'h1234, 16'h0000, w);
    issue(4'hB, 16'h1234, 16'h0003, w);
    issue(4'h4, 16'hFFFF, 16'h0001, w);

    // MUL: follow-up op must wait out the 16 iteration cycles
    issue(4'h3, 16'h0123, 16'h0011, w);
    issue(4'h1, 16'h00F0, 16'h000F, w);
    chk("mul_stall_cycles", 32'(w), 32'd16);

    // Back-to-back stream, no bubbles
    issue(4'h0, 16'hF0F0, 16'h3C3C, w); chk("b2b_and", 32'(w), 32'd0);
    issue(4'h1, 16'hF0F0, 16'h3C3C, w); chk("b2b_or", 32'(w), 32'd0);
    issue(4'h2, 16'hF0F0, 16'h3C3C, w); chk("b2b_eor", 32'(w), 32'd0);
    issue(4'h6, 16'h1234, 16'd4, w);    chk("b2b_lsl", 32'(w), 32'd0);

    // Same stream with 3 cycles of output stall after the first op
    rdy_mode = 2;
    issue(4'h0, 16'hAAAA, 16'h0FF0, w);
    fork
      issue(4'h1, 16'hAAAA, 16'h0FF0, w);
      begin
        repeat (3) @(posedge clk);
        rdy_mode = 0;
      end
    join
    chk("stall_wait_cycles", 32'(w), 32'd3);
    issue(4'h2, 16'hAAAA, 16'h0FF0, w);
    issue(4'h6, 16'hAAAA, 16'd4, w);

    // Shift boundaries
    issue(4'h6, 16'hFFFF, 16'd16, w);
    issue(4'h7, 16'hFFFF, 16'd20, w);
    issue(4'hC, 16'h8000, 16'd3, w);
    issue(4'hC, 16'h8000, 16'd99, w);
    issue(4'hC, 16'h7FFF, 16'd40, w);

    // Reset in the middle of a multiply
    issue(4'hF, 16'h0000, 16'hABCD, w);
    issue(4'h3, 16'h1234, 16'h5678, w);
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_mul_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_mul_rst_result", 32'(result), 32'd0);
    chk("mid_mul_rst_branch", 32'(branch), 32'd0);
    chk("mid_mul_rst_flags", 32'(flags), 32'd0);
    chk("mid_mul_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    seen = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    issue(4'h4, 16'd2, 16'd3, w);

    // Randomized traffic with random backpressure and idle gaps
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom);
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = 16'h0000;
      issue(op, a, b, w);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    // Drain
    rdy_mode = 0;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Registered result, branch decision and N/Z/C/V flags, with a valid/ready handshake on input and output.
- Adds an iterative shift-add multiply (MUL) and an arithmetic shift right (ASR).
- Sits between the register-read stage and writeback/branch-resolve; stalls upstream via in_ready while a result is held or a multiply is in progress.

Parameters:
- WIDTH, 16, datapath width in bits (>=4).
- CNTW, $clog2(WIDTH)+1, width of the internal multiply iteration counter (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept an operation this cycle.
- busA  input  WIDTH  operand A.
- busB  input  WIDTH  operand B.
- ALUop  input  4  opcode.
- out_valid  output  1  result/branch/flags valid.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  registered result.
- branch  output  1  registered branch-taken.
- flags  output  4  registered {N,Z,C,V}.

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 EOR, 3 MUL, 4 ADD, 5 SUB, 6 LSL, 7 LSR.
  - 8 B, 9 BL, A CBZ, B CBNZ, C ASR, F passB.
  - D, E reserved: result 0.
  - 8..B produce result 0.
- Branch: ALUop[3]=1 with ALUop[2:0] = 000 or 001 -> 1; 010 -> (busB==0); 011 -> (busB!=0); all other opcodes -> 0.
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH. C = carry out of ADD; for SUB, C = 1 when there is no borrow (busA>=busB unsigned). V = signed overflow.
  - MUL keeps the low WIDTH bits of busA*busB.
  - Shifts use the full busB value. busB>=WIDTH gives 0 for LSL/LSR; for ASR it gives all bits = busA[WIDTH-1].
- Flags:
  - N = result[WIDTH-1] and Z = (result==0) for every op.
  - C and V are meaningful only for ADD/SUB and are 0 for all other ops.
  - Flags update only when a result is loaded; they are held while out_valid is high.
- Handshake:
  - Accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - result/branch/flags are stable while out_valid=1 and out_ready=0.
- State machine IDLE / MULT / HOLD:
  - IDLE: in_ready=1. On accept of a non-MUL op, compute and load result registers, then go to HOLD (out_valid=1 on the next cycle, latency 1). On accept of MUL, latch operands, clear the accumulator, set counter=0, go to MULT.
  - MULT: in_ready=0. Each cycle, if multiplier bit0 then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++. After WIDTH iterations, load result and go to HOLD. MUL latency is WIDTH+1 cycles from accept to out_valid.
  - HOLD: out_valid=1 and in_ready=out_ready (combinational).
    - out_ready=1 with a new accept: treat as IDLE acceptance in the same cycle (back-to-back throughput of 1/cycle for non-MUL ops).
    - out_ready=1 with no accept: go to IDLE, out_valid=0 next cycle.
    - out_ready=0: stay in HOLD.
- Reset: asserting reset_n=0 at any time, including mid-MULT, aborts the operation. State -> IDLE; result=0, branch=0, flags=0, out_valid=0. in_ready=1 while in reset.
- Inputs are ignored when in_ready=0. busA/busB/ALUop need not be held after the accept cycle.

Test Plan:
- Reset, then ADD busA=16'h7FFF busB=16'h0001, out_ready=1 -> one cycle later out_valid=1, result=16'h8000, flags N=1 Z=0 C=0 V=1, branch=0.
- SUB busA=5 busB=5 -> result=0, flags Z=1 C=1 N=0 V=0. Then CBZ busB=0 -> branch=1, result=0. Then CBNZ busB=3 -> branch=1. Then ALUop=4'h4 -> branch=0.
- MUL busA=16'h0123 busB=16'h0011, with in_valid held high -> in_ready low for 16 cycles; out_valid in cycle 17 after accept; result=16'h1353; flags C=0 V=0.
- Back-to-back stream of 4 ops (AND, OR, EOR, LSL by 4), out_ready=1 -> one result per cycle with no bubbles. Repeat with out_ready=0 for 3 cycles -> result held stable and in_ready=0 until out_ready=1.
- Shift boundaries: LSL busB=16, LSR busB=20 -> result=0. ASR busA=16'h8000 busB=3 -> 16'hF000. ASR busA=16'h8000 busB=99 -> 16'hFFFF.
- Assert reset_n low at cycle 5 of a MUL -> all outputs 0 asynchronously. After release, in_ready=1; a new ADD 2+3 returns 5 with latency 1.
